// File: rtl/jtopl_eg_ctrl.sv
// jtopl_eg_ctrl: OPL envelope sequencer, round-robin slot walk with per-slot ADSR state
module jtopl_eg_ctrl #(
    parameter int SLOTS = 18,
    parameter int CW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          keyon_I,
    input  logic [3:0]    arate_I,
    input  logic [3:0]    drate_I,
    input  logic [3:0]    rrate_I,
    input  logic [3:0]    sl_I,
    input  logic          eg_type_I,
    input  logic [8:0]    eg_level_I,
    output logic [4:0]    slot,
    output logic          zero,
    output logic [CW-1:0] eg_cnt,
    output logic [1:0]    state,
    output logic          attack,
    output logic [4:0]    base_rate,
    output logic          pg_rst
);
    typedef enum logic [1:0] {ATTACK = 2'd0, DECAY = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} eg_state_t;
    eg_state_t         st_sr_q [SLOTS];
    logic [SLOTS-1:0]  kon_sr_q;
    eg_state_t         state_q, state_d;
    logic [4:0]        slot_q, slot_d, base_q, base_d;
    logic [CW-1:0]     eg_cnt_q, eg_cnt_d;
    logic              zero_q, pg_q, pg_d, wrap;
    logic [4:0]        slv;
    assign wrap     = slot_q == 5'(SLOTS - 1);
    assign slot_d   = wrap ? 5'd0 : slot_q + 5'd1;
    assign eg_cnt_d = wrap ? eg_cnt_q + CW'(1) : eg_cnt_q;
    assign slv      = sl_I == 4'hF ? 5'h1F : {1'b0, sl_I};
    // next ADSR state for the head slot; a key-on edge outranks every level-driven move
    always_comb begin
        pg_d    = keyon_I & ~kon_sr_q[0];
        state_d = st_sr_q[0];
        if (pg_d)
            state_d = ATTACK;
        else if (!keyon_I && kon_sr_q[0])
            state_d = RELEASE;
        else if (st_sr_q[0] == ATTACK && eg_level_I == 9'd0)
            state_d = DECAY;
        else if (st_sr_q[0] == DECAY && eg_level_I[8:4] >= slv)
            state_d = eg_type_I ? SUSTAIN : RELEASE;
        else if (st_sr_q[0] == SUSTAIN && !eg_type_I)
            state_d = RELEASE;
        base_d = state_d == ATTACK  ? {1'b0, arate_I} :
                 state_d == DECAY   ? {1'b0, drate_I} :
                 state_d == RELEASE ? {1'b0, rrate_I} : 5'd0;
    end
    // per-slot state ring: head is the slot being processed, its update re-enters at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) st_sr_q[i] <= RELEASE;
            kon_sr_q <= '0;
        end else if (cen) begin
            for (int i = 0; i < SLOTS - 1; i++) st_sr_q[i] <= st_sr_q[i+1];
            st_sr_q[SLOTS-1] <= state_d;
            kon_sr_q         <= {keyon_I, kon_sr_q[SLOTS-1:1]};
        end
    end
    // slot walk, round counter and registered outputs for the slot just processed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= 5'd0;
            zero_q   <= 1'b1;
            eg_cnt_q <= '0;
            state_q  <= RELEASE;
            base_q   <= 5'd0;
            pg_q     <= 1'b0;
        end else if (cen) begin
            slot_q   <= slot_d;
            zero_q   <= slot_d == 5'd0;
            eg_cnt_q <= eg_cnt_d;
            state_q  <= state_d;
            base_q   <= base_d;
            pg_q     <= pg_d;
        end
    end
    assign slot      = slot_q;
    assign zero      = zero_q;
    assign eg_cnt    = eg_cnt_q;
    assign state     = state_q;
    assign attack    = state_q == ATTACK;
    assign base_rate = base_q;
    assign pg_rst    = pg_q;
endmodule
